// File: rtl/kalman_filter_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : kalman_filter_mc_if
// Function : Sample-in / estimate-out bus of the multi-channel Kalman filter.
// Revision : 1.0  initial release
// ============================================================================
interface kalman_filter_mc_if #(
    parameter int DW = 13,
    parameter int CW = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        in_ch;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [DW-1:0] out_data;

    modport master (
        output in_valid, in_ch, in_data,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface
`default_nettype wire

// File: rtl/kalman_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : kalman_filter_mc
// Function : Time-multiplexed 1-D scalar Kalman filter with CH independent
//            channels sharing one saturating datapath.
// Revision : 1.0  initial release
// ============================================================================
module kalman_filter_mc #(
    parameter int DW    = 13,
    parameter int CH    = 3,
    parameter int CW    = 2,
    parameter int FRAC  = 12,
    parameter int Q_DEF = 1,
    parameter int R_DEF = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [DW-2:0]     q_cfg,
    input  logic [DW-2:0]     r_cfg,
    input  logic              clr,
    kalman_filter_mc_if.slave bus
);
    localparam int PW  = DW - 1;           // covariance width (unsigned)
    localparam int NW  = DW + FRAC;        // gain numerator width
    localparam int KW  = FRAC + 1;         // gain width, holds 1.0
    localparam int MXW = KW + DW + 2;      // signed K*innov product width
    localparam int MPW = KW + PW;          // unsigned K*P product width

    localparam logic [PW-1:0]         c_P_MAX = '1;
    localparam logic [KW-1:0]         c_K_ONE = {1'b1, {FRAC{1'b0}}};
    localparam logic signed [MXW-1:0] c_X_MAX = MXW'((1 << (DW-1)) - 1);
    localparam logic signed [MXW-1:0] c_X_MIN = ~c_X_MAX;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRED = 3'd1,
        S_GAIN = 3'd2,
        S_DIV  = 3'd3,
        S_MUL  = 3'd4,
        S_SUM  = 3'd5,
        S_WB   = 3'd6
    } state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_x [CH];
    logic [PW-1:0]         r_p [CH];
    logic [CH-1:0]         r_seeded;
    logic [PW-1:0]         r_q;
    logic [PW-1:0]         r_r;
    logic [PW-1:0]         r_q_s;
    logic [PW-1:0]         r_r_s;
    logic signed [DW-1:0]  r_z;
    logic [CW-1:0]         r_ch;
    logic                  r_seed;
    logic signed [DW-1:0]  r_xf;
    logic [PW-1:0]         r_pf;
    logic [NW-1:0]         r_num;
    logic [DW:0]           r_den;
    logic signed [DW:0]    r_innov;
    logic [KW-1:0]         r_k;
    logic signed [MXW-1:0] r_mx;
    logic [MPW-1:0]        r_mp;
    logic signed [DW-1:0]  r_xn;
    logic [PW-1:0]         r_pn;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CW-1:0]         r_out_ch;
    logic signed [DW-1:0]  r_out_data;

    logic                  w_ch_ok;
    logic [PW:0]           w_psum;
    logic [NW-1:0]         w_quot;
    logic [KW-1:0]         w_k;
    logic signed [MXW-1:0] w_xsum;
    logic signed [DW-1:0]  w_xn;
    logic [MPW-1:0]        w_mp_sh;
    logic [PW-1:0]         w_pn;

    always_comb begin
        w_ch_ok = (int'(bus.in_ch) < CH);
        w_psum  = {1'b0, r_p[r_ch]} + {1'b0, r_q_s};

        // Zero denominator yields zero gain; the divider never sees it.
        w_quot = '0;
        w_k    = '0;
        if (r_den != '0) begin
            w_quot = r_num / NW'(r_den);
            w_k    = (w_quot > NW'(c_K_ONE)) ? c_K_ONE : w_quot[KW-1:0];
        end

        w_xsum = MXW'(r_xf) + (r_mx >>> FRAC);
        if (w_xsum > c_X_MAX)
            w_xn = c_X_MAX[DW-1:0];
        else if (w_xsum < c_X_MIN)
            w_xn = c_X_MIN[DW-1:0];
        else
            w_xn = w_xsum[DW-1:0];

        w_mp_sh = r_mp >> FRAC;
        if (w_mp_sh >= MPW'(r_pf))
            w_pn = '0;
        else
            w_pn = r_pf - w_mp_sh[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < CH; i++) begin
                r_x[i] <= '0;
                r_p[i] <= '0;
            end
            r_seeded    <= '0;
            r_q         <= PW'(Q_DEF);
            r_r         <= PW'(R_DEF);
            r_q_s       <= PW'(Q_DEF);
            r_r_s       <= PW'(R_DEF);
            r_z         <= '0;
            r_ch        <= '0;
            r_seed      <= 1'b0;
            r_xf        <= '0;
            r_pf        <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_innov     <= '0;
            r_k         <= '0;
            r_mx        <= '0;
            r_mp        <= '0;
            r_xn        <= '0;
            r_pn        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (cfg_we) begin
                r_q <= q_cfg;
                r_r <= r_cfg;
            end
            // The WB bit-set below is later in the block, so an in-flight
            // sample re-marks its own channel even if clr lands on WB.
            if (clr)
                r_seeded <= '0;

            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready && w_ch_ok) begin
                        r_z        <= bus.in_data;
                        r_ch       <= bus.in_ch;
                        r_q_s      <= r_q;
                        r_r_s      <= r_r;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PRED;
                    end
                end
                S_PRED: begin
                    r_xf    <= r_x[r_ch];
                    r_pf    <= w_psum[PW] ? c_P_MAX : w_psum[PW-1:0];
                    r_seed  <= ~r_seeded[r_ch];
                    r_state <= S_GAIN;
                end
                S_GAIN: begin
                    r_num   <= NW'(r_pf) << FRAC;
                    r_den   <= (DW+1)'(r_pf) + (DW+1)'(r_r_s);
                    r_innov <= (DW+1)'(r_z) - (DW+1)'(r_xf);
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_k     <= w_k;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_mx    <= MXW'($signed({1'b0, r_k})) * MXW'(r_innov);
                    r_mp    <= MPW'(r_k) * MPW'(r_pf);
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_xn    <= r_seed ? r_z : w_xn;
                    r_pn    <= r_seed ? r_r_s : w_pn;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_x[r_ch]      <= r_xn;
                    r_p[r_ch]      <= r_pn;
                    r_seeded[r_ch] <= 1'b1;
                    r_out_data     <= r_xn;
                    r_out_ch       <= r_ch;
                    r_out_valid    <= 1'b1;
                    r_in_ready     <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_kalman_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_kalman_filter_mc
// Function : Directed self-checking bench for kalman_filter_mc.
// Revision : 1.0  initial release
// ============================================================================
module tb_kalman_filter_mc;
    localparam int DW = 13;
    localparam int CW = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          cfg_we = 1'b0;
    logic          clr    = 1'b0;
    logic [DW-2:0] q_cfg  = '0;
    logic [DW-2:0] r_cfg  = '0;

    kalman_filter_mc_if #(.DW(DW), .CW(CW)) bus ();

    kalman_filter_mc #(
        .DW(DW), .CH(3), .CW(CW), .FRAC(12), .Q_DEF(1), .R_DEF(64)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_we (cfg_we),
        .q_cfg  (q_cfg),
        .r_cfg  (r_cfg),
        .clr    (clr),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int ecnt     = 0;
    int last_acc = 0;
    int prev_acc = 0;
    int cnt      = 0;
    bit seen     = 1'b0;

    // Edge counter and edge index of the most recent accepted sample.
    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (bus.in_valid && bus.in_ready)
            last_acc = ecnt;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_cfg(input int q, input int r);
        @(negedge clk);
        cfg_we = 1'b1;
        q_cfg  = q[DW-2:0];
        r_cfg  = r[DW-2:0];
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // mid_kind: 0 none, 1 write R=4095 mid-sample, 2 clr pulse mid-sample
    task automatic run_sample(input string tag, input int ch, input int z,
                              input int exp_x, input bit with_clr,
                              input int mid_at, input int mid_kind);
        int lat;
        bit got;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch[CW-1:0];
        bus.in_data  = z[DW-1:0];
        clr          = with_clr;
        for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr          = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            if (lat == mid_at && mid_kind == 1) begin
                cfg_we = 1'b1;
                r_cfg  = 12'd4095;
            end
            if (lat == mid_at && mid_kind == 2)
                clr = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
            clr    = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, got ? lat : -1, 7);
        check({tag, "_data"}, $signed(bus.out_data), exp_x);
        check({tag, "_ch"}, bus.out_ch, ch);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_out_data", $signed(bus.out_data), 0);
        rst_n = 1'b1;

        // Seed and converge on ch0 with Q=0, R=64.
        set_cfg(0, 64);
        run_sample("seed0", 0, 0, 0, 1'b0, 0, 0);
        run_sample("conv1", 0, 1000, 500, 1'b0, 0, 0);
        run_sample("conv2", 0, 1000, 666, 1'b0, 0, 0);

        // Channel independence from a freshly seeded zero state.
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        run_sample("ind_seed0", 0, 0, 0, 1'b0, 0, 0);
        run_sample("ind_seed1", 1, 0, 0, 1'b0, 0, 0);
        run_sample("ind_ch0", 0, 1000, 500, 1'b0, 0, 0);
        run_sample("ind_ch1", 1, -1000, -500, 1'b0, 0, 0);

        // Back-to-back accepts with in_valid held on ch2, z=0.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd2;
        bus.in_data  = '0;
        for (int n = 0; n < 3; n++) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (n == 2) bus.in_valid = 1'b0;
            check("hold_seen", seen, 1);
            check("hold_data", $signed(bus.out_data), 0);
            check("hold_ch", bus.out_ch, 2);
            check("hold_ready_rise", bus.in_ready, 1);
            check("hold_lat", ecnt - last_acc, 6);
            if (n > 0) check("hold_spacing", last_acc - prev_acc, 7);
            prev_acc = last_acc;
            @(negedge clk);
            check("hold_pulse", bus.out_valid, 0);
            check("hold_ready_next", bus.in_ready, (n == 2) ? 1 : 0);
        end

        // R rewritten mid-sample: in-flight uses R=64, next one uses 4095.
        run_sample("cfg_mid", 0, 1000, 666, 1'b0, 2, 1);
        run_sample("cfg_new", 0, 1000, 667, 1'b0, 0, 0);

        // clr with simultaneous accept reseeds; clr also clears ch1.
        run_sample("clr_acc", 0, -300, -300, 1'b1, 0, 0);
        run_sample("clr_ch1", 1, 777, 777, 1'b0, 0, 0);
        // clr mid-operation: sample completes and keeps ch1 seeded.
        run_sample("clr_mid", 1, 1777, 1277, 1'b0, 3, 2);
        run_sample("clr_after", 1, 3277, 1943, 1'b0, 0, 0);

        // Out-of-range channel is swallowed.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd3;
        bus.in_data  = 13'sd123;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("badch_ready", bus.in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("badch_no_out", cnt, 0);

        // Zero denominator: P=0 and R=0 give K=0, estimate holds.
        set_cfg(0, 0);
        run_sample("zden_seed", 2, 100, 100, 1'b0, 0, 0);
        run_sample("zden_hold", 2, 2000, 100, 1'b0, 0, 0);

        // P saturates at 4095 with Q=4095; gain stays at K=4032.
        set_cfg(4095, 64);
        run_sample("psat1", 2, 1100, 1084, 1'b0, 0, 0);
        run_sample("psat2", 2, 2084, 2068, 1'b0, 0, 0);
        run_sample("psat3", 2, -2000, -1937, 1'b0, 0, 0);

        // Reset during MUL aborts the sample.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.in_data  = 13'sd999;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_valid", bus.out_valid, 0);
        check("rstmid_data", $signed(bus.out_data), 0);
        check("rstmid_ch", bus.out_ch, 0);
        check("rstmid_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("rstmid_no_out", cnt, 0);

        // Defaults restored (Q=1, R=64): reseed then one update.
        run_sample("post_seed", 0, 50, 50, 1'b0, 0, 0);
        run_sample("post_upd", 0, 1050, 553, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
